rle_stream_decoder: RTL and testbench

RLE_STREAM_DECODER -- requirements
Module: rle_stream_decoder

---
 rtl/rle_pkg.sv | 21 ++
 rtl/rle_byte_packer.sv | 103 ++++++++++
 rtl/rle_stream_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_rle_stream_decoder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE stream decoder.
package rle_pkg;

    localparam logic [7:0]  RLE_ESC_DEFAULT = 8'h07;
    localparam int unsigned RLE_MAX_RUN     = 255;
    localparam int unsigned RLE_CNT_W       = $clog2(RLE_MAX_RUN + 1);

    typedef enum logic [1:0] {
        ST_LIT,
        ST_ESC_SEEN,
        ST_CNT_SEEN,
        ST_RUN
    } rle_state_t;

    // One decoded byte handed from the parser to the packer.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } rle_beat_t;

endpackage

// File: rtl/rle_byte_packer.sv
// Packs decoded bytes into output words; holds the word until accepted and
// closes a frame either with its final byte or with an explicit flush.
module rle_byte_packer
    import rle_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_beat_valid,
    input  rle_beat_t               i_beat,
    output logic                    o_beat_ready,
    input  logic                    i_flush,
    output logic                    o_flush_ready,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WORD_BYTES*8-1:0] o_data,
    output logic [WORD_BYTES-1:0]   o_keep,
    output logic                    o_last
);

    localparam int unsigned DATA_W = WORD_BYTES * 8;
    localparam int unsigned CNT_W  = $clog2(WORD_BYTES);

    logic [DATA_W-1:0]     r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [WORD_BYTES-1:0] r_keep;
    logic                  r_last;

    logic                  w_out_free;
    logic                  w_full_next;
    logic                  w_wr;
    logic                  w_close;
    logic [DATA_W-1:0]     w_acc_ins;
    logic [WORD_BYTES-1:0] w_keep_ins;
    logic [WORD_BYTES-1:0] w_keep_acc;

    // Output register is free when empty or being taken this cycle.
    assign w_out_free    = !r_valid || i_ready;
    assign w_full_next   = (r_cnt == CNT_W'(WORD_BYTES - 1));
    assign o_beat_ready  = w_out_free || (!i_beat.last && !w_full_next);
    assign o_flush_ready = w_out_free;
    assign w_wr          = i_beat_valid && o_beat_ready;
    assign w_close       = i_beat.last || w_full_next;

    // Accumulator with the incoming byte inserted, and keep masks with/without it.
    always_comb begin
        w_acc_ins  = r_acc;
        w_keep_ins = '0;
        w_keep_acc = '0;
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_acc_ins[8*b +: 8] = i_beat.data;
            end
            w_keep_ins[b] = (CNT_W'(b) <= r_cnt);
            w_keep_acc[b] = (CNT_W'(b) <  r_cnt);
        end
    end

    // Accumulate bytes; move complete or final words into the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else begin
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_wr) begin
                if (w_close) begin
                    r_data  <= w_acc_ins;
                    r_keep  <= w_keep_ins;
                    r_last  <= i_beat.last;
                    r_valid <= 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_acc_ins;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (i_flush && w_out_free) begin
                r_data  <= r_acc;
                r_keep  <= w_keep_acc;
                r_last  <= 1'b1;
                r_valid <= 1'b1;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: rtl/rle_stream_decoder.sv
// Run-length stream decoder: unpacks coded words, parses escape sequences one
// byte per cycle and feeds decoded bytes to the output packer.
module rle_stream_decoder
    import rle_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [7:0]  ESC_CHAR   = RLE_ESC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_BYTES*8-1:0] in_data,
    input  logic [WORD_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_BYTES*8-1:0] out_data,
    output logic [WORD_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic                    err
);

    localparam int unsigned DATA_W = WORD_BYTES * 8;

    rle_state_t            r_state;
    logic [RLE_CNT_W-1:0]  r_cnt;
    logic [7:0]            r_sym;
    logic                  r_end_pend;
    logic                  r_err;
    logic [DATA_W-1:0]     r_data;
    logic [WORD_BYTES-1:0] r_keep;
    logic                  r_last;
    logic                  r_loaded;

    rle_state_t            w_state_nxt;
    logic [RLE_CNT_W-1:0]  w_cnt_nxt;
    logic [7:0]            w_sym_nxt;
    logic                  w_end_nxt;
    logic                  w_err_nxt;
    logic [DATA_W-1:0]     w_data_nxt;
    logic [WORD_BYTES-1:0] w_keep_nxt;
    logic                  w_last_nxt;
    logic                  w_loaded_nxt;

    logic [7:0]            w_cur_byte;
    logic [WORD_BYTES-1:0] w_keep_rest;
    logic                  w_byte_avail;
    logic                  w_skip;
    logic                  w_final_byte;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_pk_valid;
    logic                  w_pk_flush;
    logic                  w_pk_ready;
    logic                  w_flush_ready;
    rle_beat_t             w_pk_beat;

    // A new word is taken only when the previous one is drained and no frame end is pending.
    assign in_ready     = !rst && !r_loaded && !r_end_pend;
    assign w_accept     = in_valid && in_ready;
    assign w_cur_byte   = r_data[7:0];
    assign w_keep_rest  = r_keep >> 1;
    assign w_byte_avail = r_loaded && r_keep[0];
    assign w_skip       = r_loaded && !r_keep[0];
    assign w_final_byte = r_last && (w_keep_rest == '0);

    // Byte offered to the packer and whether it is the last decoded byte of the frame.
    always_comb begin
        w_pk_beat = '{data: w_cur_byte, last: 1'b0};
        case (r_state)
            ST_LIT: w_pk_beat.last = w_final_byte;
            ST_ESC_SEEN: begin
                w_pk_beat.data = ESC_CHAR;
                w_pk_beat.last = w_final_byte;
            end
            ST_RUN: begin
                w_pk_beat.data = r_sym;
                w_pk_beat.last = r_end_pend && (r_cnt == RLE_CNT_W'(1));
            end
            default: ;
        endcase
    end

    // Parser next-state, packer requests and unpacker advance.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sym_nxt    = r_sym;
        w_end_nxt    = r_end_pend;
        w_err_nxt    = 1'b0;
        w_data_nxt   = r_data;
        w_keep_nxt   = r_keep;
        w_last_nxt   = r_last;
        w_loaded_nxt = r_loaded;
        w_pk_valid   = 1'b0;
        w_pk_flush   = 1'b0;
        w_consume    = 1'b0;

        case (r_state)
            ST_LIT: begin
                if (w_byte_avail) begin
                    if (w_cur_byte == ESC_CHAR) begin
                        w_consume   = 1'b1;
                        w_state_nxt = ST_ESC_SEEN;
                    end else begin
                        w_pk_valid = 1'b1;
                        w_consume  = w_pk_ready;
                    end
                end else if (r_end_pend) begin
                    w_pk_flush = 1'b1;
                    if (w_flush_ready) begin
                        w_end_nxt = 1'b0;
                    end
                end
            end
            ST_ESC_SEEN: begin
                if (w_byte_avail) begin
                    if (w_cur_byte == 8'h00) begin
                        w_pk_valid = 1'b1;
                        w_consume  = w_pk_ready;
                        if (w_pk_ready) begin
                            w_state_nxt = ST_LIT;
                        end
                    end else begin
                        w_consume   = 1'b1;
                        w_cnt_nxt   = RLE_CNT_W'(w_cur_byte);
                        w_state_nxt = ST_CNT_SEEN;
                    end
                end else if (r_end_pend) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_LIT;
                end
            end
            ST_CNT_SEEN: begin
                if (w_byte_avail) begin
                    w_consume   = 1'b1;
                    w_sym_nxt   = w_cur_byte;
                    w_state_nxt = ST_RUN;
                end else if (r_end_pend) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_LIT;
                end
            end
            ST_RUN: begin
                w_pk_valid = 1'b1;
                if (w_pk_ready) begin
                    w_cnt_nxt = r_cnt - RLE_CNT_W'(1);
                    if (r_cnt == RLE_CNT_W'(1)) begin
                        w_state_nxt = ST_LIT;
                        if (r_end_pend) begin
                            w_end_nxt = 1'b0;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_LIT;
        endcase

        if (w_accept) begin
            w_data_nxt   = in_data;
            w_keep_nxt   = in_keep;
            w_last_nxt   = in_last;
            w_loaded_nxt = |in_keep;
            w_end_nxt    = in_last && (in_keep == '0);
        end else if (w_consume || w_skip) begin
            w_data_nxt = r_data >> 8;
            w_keep_nxt = w_keep_rest;
            if (w_keep_rest == '0) begin
                w_loaded_nxt = 1'b0;
                // Frame end still needs handling unless this byte already closed the frame.
                if (r_last && !(w_pk_valid && w_pk_beat.last)) begin
                    w_end_nxt = 1'b1;
                end
            end
        end
    end

    // Parser and unpacker state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LIT;
            r_cnt      <= '0;
            r_sym      <= '0;
            r_end_pend <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
            r_keep     <= '0;
            r_last     <= 1'b0;
            r_loaded   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sym      <= w_sym_nxt;
            r_end_pend <= w_end_nxt;
            r_err      <= w_err_nxt;
            r_data     <= w_data_nxt;
            r_keep     <= w_keep_nxt;
            r_last     <= w_last_nxt;
            r_loaded   <= w_loaded_nxt;
        end
    end

    assign err = r_err;

    rle_byte_packer #(
        .WORD_BYTES(WORD_BYTES)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_beat_valid (w_pk_valid),
        .i_beat       (w_pk_beat),
        .o_beat_ready (w_pk_ready),
        .i_flush      (w_pk_flush),
        .o_flush_ready(w_flush_ready),
        .o_valid      (out_valid),
        .i_ready      (out_ready),
        .o_data       (out_data),
        .o_keep       (out_keep),
        .o_last       (out_last)
    );

endmodule

// File: tb/tb_rle_stream_decoder.sv
// Directed bench for rle_stream_decoder (WORD_BYTES=4, ESC=07).
module tb_rle_stream_decoder;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } owd_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        err;

    int   checks   = 0;
    int   failures = 0;
    int   err_cnt  = 0;
    owd_t q[$];

    rle_stream_decoder #(
        .WORD_BYTES(4),
        .ESC_CHAR  (8'h07)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_keep  (in_keep),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture accepted output words and err cycles away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back({out_data, out_keep, out_last});
        if (!rst && err) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] msk(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_word in_ready timeout got=0 exp=1 data=%h", d);
        end
    endtask

    task automatic wait_words(input int n);
        for (int c = 0; c < 600 && q.size() < n; c++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_keep, err, in_ready} !== 8'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b l=%b k=%b e=%b rdy=%b exp all 0",
                     out_valid, out_last, out_keep, err, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_literal();
        owd_t exp[$];
        owd_t got;
        q.delete();
        send_word(32'h44434241, 4'hF, 1'b1);
        exp.push_back({32'h44434241, 4'hF, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL literal count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL literal word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_run();
        owd_t exp[$];
        owd_t got;
        q.delete();
        send_word(32'h59580507, 4'hF, 1'b1);
        exp.push_back({32'h58585858, 4'hF, 1'b0});
        exp.push_back({32'h00005958, 4'h3, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL run count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL run word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_esc_literal();
        owd_t exp[$];
        owd_t got;
        q.delete();
        err_cnt = 0;
        send_word(32'h42410007, 4'hF, 1'b1);
        exp.push_back({32'h00424107, 4'h7, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL esc_lit count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL esc_lit word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL esc_lit err_cycles got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_stall();
        owd_t exp[$];
        owd_t got;
        q.delete();
        out_ready = 1'b0;
        send_word(32'h03075251, 4'hF, 1'b0);
        send_word(32'h0000005A, 4'h1, 1'b1);
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({out_valid, out_data, out_keep, out_last} !== {1'b1, 32'h5A5A5251, 4'hF, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold cycle%0d got=%b/%h/%b/%b exp=1/5a5a5251/1111/0", c, out_valid, out_data, out_keep, out_last);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        exp.push_back({32'h5A5A5251, 4'hF, 1'b0});
        exp.push_back({32'h0000005A, 4'h1, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL stall count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL stall word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_err();
        owd_t exp[$];
        owd_t got;
        q.delete();
        err_cnt = 0;
        send_word(32'h00030741, 4'h7, 1'b1);
        exp.push_back({32'h00000041, 4'h1, 1'b1});
        wait_words(exp.size());
        checks++;
        if (err_cnt != 1) begin failures++; $display("FAIL err_pulse cycles got=%0d exp=1", err_cnt); end
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL err count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL err word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_escape_span();
        owd_t exp[$];
        owd_t got;
        q.delete();
        send_word(32'h07434241, 4'hF, 1'b0);
        send_word(32'h00004B02, 4'h3, 1'b1);
        exp.push_back({32'h4B434241, 4'hF, 1'b0});
        exp.push_back({32'h0000004B, 4'h1, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL span count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL span word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_empty_frame();
        owd_t exp[$];
        owd_t got;
        q.delete();
        send_word(32'h00000000, 4'h0, 1'b1);
        exp.push_back({32'h00000000, 4'h0, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL empty count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL empty word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_back_to_back();
        owd_t exp[$];
        owd_t got;
        q.delete();
        send_word(32'h00004241, 4'h3, 1'b1);
        send_word(32'h00004443, 4'h3, 1'b1);
        exp.push_back({32'h00004241, 4'h3, 1'b1});
        exp.push_back({32'h00004443, 4'h3, 1'b1});
        wait_words(exp.size());
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL b2b count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL b2b word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        owd_t exp[$];
        owd_t got;
        send_word(32'h004DC807, 4'h7, 1'b1);
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_out_valid got v=%b rdy=%b exp v=0 rdy=0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        q.delete();
        err_cnt = 0;
        send_word(32'h44434241, 4'hF, 1'b1);
        exp.push_back({32'h44434241, 4'hF, 1'b1});
        wait_words(exp.size());
        repeat (20) @(negedge clk);
        checks++;
        if (q.size() != exp.size()) begin failures++; $display("FAIL midrst count got=%0d exp=%0d", q.size(), exp.size()); end
        foreach (exp[i]) begin
            got = (i < q.size()) ? q[i] : '0;
            checks++;
            if ({got.d & msk(exp[i].k), got.k, got.l} !== exp[i]) begin
                failures++;
                $display("FAIL midrst word%0d got=%h/%b/%b exp=%h/%b/%b", i, got.d, got.k, got.l, exp[i].d, exp[i].k, exp[i].l);
            end
        end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL midrst err_cycles got=%0d exp=0", err_cnt); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_literal();
        test_run();
        test_esc_literal();
        test_stall();
        test_err();
        test_escape_span();
        test_empty_frame();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
